// File: rtl/clk_check.sv
// Receive-side monitor for a divided clock: edge strobes, half-period measurement, lock/error status.
// Optional macro CLK_CHECK_STICKY_EN turns err_freq into a level held until sclr.
module clk_check #(
    parameter int unsigned FREQ_CLK    = 2_000_000,
    parameter int unsigned FREQ_OUT    = 250_000,
    parameter int unsigned TOL         = 1,
    parameter int unsigned LOCK_CNT    = 4,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned HALF       = FREQ_CLK / FREQ_OUT / 2,
    localparam int unsigned LOST_MAX   = 2 * HALF + TOL,
    localparam int unsigned CW         = $clog2(LOST_MAX + 1)
) (
    input  logic          clk_in,
    input  logic          sclr,
    input  logic          sig_in,
    output logic          rise_stb,
    output logic          fall_stb,
    output logic [CW-1:0] period,
    output logic          period_vld,
    output logic          locked,
    output logic          err_freq,
    output logic          err_lost
);

    localparam int unsigned GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT);
    localparam int unsigned LO = (TOL >= HALF) ? 1 : HALF - TOL;
    localparam int unsigned HI = HALF + TOL;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEAS = 2'd1,
        LOCK = 2'd2,
        LOST = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [GW-1:0]          good_cnt;
    logic [GW-1:0]          good_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic                   sync_out;
    logic                   edge_det;
    logic [CW-1:0]          cnt;
    logic                   sat;
    logic                   m_good;
    logic                   upd;
    logic                   bad;

    assign sync_out = sync[SYNC_STAGES-1];
    assign edge_det = sync_out ^ hist;
    assign sat      = (cnt == CW'(LOST_MAX));
    assign m_good   = (cnt >= CW'(LO)) && (cnt <= CW'(HI));
    assign upd      = edge_det && ((state == MEAS) || (state == LOCK));
    assign bad      = upd && !m_good;

    // State register and good-measurement counter
    always_ff @(posedge clk_in) begin
        if (sclr) begin
            state    <= IDLE;
            good_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
        end
    end

    // Next-state: an edge always takes priority over the loss-of-clock timeout
    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        case (state)
            IDLE: begin
                if (edge_det) begin
                    state_nxt = MEAS;
                    good_nxt  = '0;
                end else if (sat) begin
                    state_nxt = LOST;
                end
            end
            MEAS: begin
                if (edge_det) begin
                    if (!m_good) begin
                        good_nxt = '0;
                    end else if (good_cnt == GW'(LOCK_CNT - 1)) begin
                        state_nxt = LOCK;
                        good_nxt  = '0;
                    end else begin
                        good_nxt = good_cnt + GW'(1);
                    end
                end else if (sat) begin
                    state_nxt = LOST;
                end
            end
            LOCK: begin
                if (edge_det) begin
                    if (!m_good) begin
                        state_nxt = MEAS;
                        good_nxt  = '0;
                    end
                end else if (sat) begin
                    state_nxt = LOST;
                end
            end
            LOST: begin
                if (edge_det) begin
                    state_nxt = MEAS;
                    good_nxt  = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                good_nxt  = '0;
            end
        endcase
    end

    // Synchronizer, half-period counter and registered outputs
    always_ff @(posedge clk_in) begin
        if (sclr) begin
            sync       <= '0;
            hist       <= 1'b0;
            cnt        <= '0;
            rise_stb   <= 1'b0;
            fall_stb   <= 1'b0;
            period     <= '0;
            period_vld <= 1'b0;
            locked     <= 1'b0;
            err_freq   <= 1'b0;
            err_lost   <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sig_in};
            hist <= sync_out;
            if (edge_det) begin
                cnt <= CW'(1);
            end else if (!sat) begin
                cnt <= cnt + CW'(1);
            end
            rise_stb   <= edge_det & sync_out;
            fall_stb   <= edge_det & ~sync_out;
            if (upd) begin
                period <= cnt;
            end
            period_vld <= upd;
            locked     <= (state == LOCK);
            err_lost   <= (state == LOST);
`ifdef CLK_CHECK_STICKY_EN
            err_freq   <= err_freq | bad;
`else
            err_freq   <= bad;
`endif
        end
    end

endmodule

// File: tb/tb_clk_check.sv
// Self-checking bench for clk_check: directed half-period scenarios plus random stimulus
// compared every cycle against a timestamp-based reference model.
module tb_clk_check;

    localparam int unsigned HALF        = 4;
    localparam int unsigned TOL         = 1;
    localparam int unsigned LOCK_CNT    = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned LOST_MAX    = 2 * HALF + TOL;
    localparam int unsigned CW          = 4;
    localparam int          LO          = HALF - TOL;
    localparam int          HI          = HALF + TOL;
    localparam int          M_IDLE = 0, M_MEAS = 1, M_LOCK = 2, M_LOST = 3;

    logic          clk_in = 1'b0;
    logic          sclr   = 1'b1;
    logic          sig_in = 1'b0;
    logic          rise_stb, fall_stb, period_vld, locked, err_freq, err_lost;
    logic [CW-1:0] period;

    clk_check dut (
        .clk_in    (clk_in),
        .sclr      (sclr),
        .sig_in    (sig_in),
        .rise_stb  (rise_stb),
        .fall_stb  (fall_stb),
        .period    (period),
        .period_vld(period_vld),
        .locked    (locked),
        .err_freq  (err_freq),
        .err_lost  (err_lost)
    );

    always #5 clk_in = ~clk_in;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    logic lvl      = 1'b0;

    // Reference model: sampled-input history, last-edge timestamp, mode
    int samp[$];
    int anchor, mode, good;
    int e_rise, e_fall, e_period, e_pv, e_locked, e_ferr, e_lost;

    task automatic model_step(input int v, input int r);
        int cnt, lv, ok, bad;
        if (r != 0) begin
            samp.delete();
            repeat (SYNC_STAGES + 2) samp.push_back(0);
            anchor = cyc; mode = M_IDLE; good = 0;
            e_rise = 0; e_fall = 0; e_period = 0; e_pv = 0;
            e_locked = 0; e_ferr = 0; e_lost = 0;
            return;
        end
        samp.push_back(v);
        void'(samp.pop_front());
        lv  = samp[1];
        cnt = cyc - 1 - anchor;
        if (cnt > int'(LOST_MAX)) cnt = int'(LOST_MAX);
        e_locked = (mode == M_LOCK) ? 1 : 0;
        e_lost   = (mode == M_LOST) ? 1 : 0;
        e_rise = 0; e_fall = 0; e_pv = 0; bad = 0;
        if (samp[1] != samp[0]) begin
            e_rise = lv; e_fall = 1 - lv;
            if (mode == M_MEAS || mode == M_LOCK) begin
                e_period = cnt; e_pv = 1;
                ok  = (cnt >= LO && cnt <= HI) ? 1 : 0;
                bad = 1 - ok;
                if (mode == M_MEAS) begin
                    if (ok != 0) begin
                        good++;
                        if (good == int'(LOCK_CNT)) begin mode = M_LOCK; good = 0; end
                    end else good = 0;
                end else if (ok == 0) begin
                    mode = M_MEAS; good = 0;
                end
            end else begin
                mode = M_MEAS; good = 0;
            end
            anchor = cyc - 1;
        end else if (cnt == int'(LOST_MAX)) begin
            mode = M_LOST;
        end
`ifdef CLK_CHECK_STICKY_EN
        e_ferr = (e_ferr != 0 || bad != 0) ? 1 : 0;
`else
        e_ferr = bad;
`endif
    endtask

    function automatic logic [9:0] exp_vec();
        return {e_rise[0], e_fall[0], CW'(e_period), e_pv[0], e_locked[0], e_ferr[0], e_lost[0]};
    endfunction

    function automatic logic [9:0] dut_vec();
        return {rise_stb, fall_stb, period, period_vld, locked, err_freq, err_lost};
    endfunction

    task automatic tick(input logic v, input logic r);
        @(negedge clk_in);
        sig_in = v;
        sclr   = r;
        cyc++;
        model_step(int'(v), int'(r));
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) begin
            tick(1'b0, 1'b1);
            vectors++;
            if (dut_vec() !== 10'd0) begin
                miscompares++;
                $display("FAIL reset cyc=%0d got=%b exp=%b", cyc, dut_vec(), 10'd0);
            end
        end
        lvl = 1'b0;
    endtask

    task automatic test_lock();
        for (int h = 0; h < 12; h++) begin
            lvl = ~lvl;
            for (int c = 0; c < int'(HALF); c++) begin
                tick(lvl, 1'b0);
                vectors++;
                if (dut_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL lock cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
                end
            end
        end
        vectors++;
        if (locked !== 1'b1 || period !== 4'd4 || err_lost !== 1'b0 || err_freq !== 1'b0) begin
            miscompares++;
            $display("FAIL lock_final locked=%b period=%0d err_lost=%b err_freq=%b exp 1/4/0/0",
                     locked, period, err_lost, err_freq);
        end
    endtask

    task automatic test_freq_err();
        int lens[7] = '{7, 4, 4, 4, 4, 4, 4};
        int saw = 0;
        foreach (lens[h]) begin
            lvl = ~lvl;
            for (int c = 0; c < lens[h]; c++) begin
                tick(lvl, 1'b0);
                if (err_freq === 1'b1 && period === 4'd7) saw = 1;
                vectors++;
                if (dut_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL freq_err cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
                end
            end
        end
        vectors++;
        if (saw != 1 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL freq_err_final saw_err7=%0d locked=%b exp 1/1", saw, locked);
        end
    endtask

    task automatic test_lost();
        for (int c = 0; c < 15; c++) begin
            tick(lvl, 1'b0);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL lost_hold cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (err_lost !== 1'b1 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL lost_flag err_lost=%b locked=%b exp 1/0", err_lost, locked);
        end
        for (int h = 0; h < 8; h++) begin
            lvl = ~lvl;
            for (int c = 0; c < int'(HALF); c++) begin
                tick(lvl, 1'b0);
                vectors++;
                if (dut_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL lost_resume cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
                end
            end
        end
        vectors++;
        if (err_lost !== 1'b0 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL lost_relock err_lost=%b locked=%b exp 0/1", err_lost, locked);
        end
    endtask

    task automatic test_tolerance();
        int lens_a[5] = '{3, 5, 3, 5, 4};
        int lens_b[9] = '{2, 4, 4, 4, 4, 4, 6, 4, 4};
        int nerr = 0;
        foreach (lens_a[h]) begin
            lvl = ~lvl;
            for (int c = 0; c < lens_a[h]; c++) begin
                tick(lvl, 1'b0);
                if (err_freq === 1'b1) nerr++;
                vectors++;
                if (dut_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL tol_edge cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
                end
            end
        end
        vectors++;
        if (locked !== 1'b1 || nerr != 0) begin
            miscompares++;
            $display("FAIL tol_accept locked=%b err_cycles=%0d exp 1/0", locked, nerr);
        end
        foreach (lens_b[h]) begin
            lvl = ~lvl;
            for (int c = 0; c < lens_b[h]; c++) begin
                tick(lvl, 1'b0);
                if (err_freq === 1'b1) nerr++;
                vectors++;
                if (dut_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL tol_reject cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
                end
            end
        end
        vectors++;
`ifdef CLK_CHECK_STICKY_EN
        if (err_freq !== 1'b1) begin
            miscompares++;
            $display("FAIL tol_sticky err_freq=%b exp 1", err_freq);
        end
`else
        if (nerr != 2) begin
            miscompares++;
            $display("FAIL tol_pulses err_cycles=%0d exp 2", nerr);
        end
`endif
    endtask

    task automatic test_sclr_mid();
        for (int h = 0; h < 7; h++) begin
            lvl = ~lvl;
            for (int c = 0; c < int'(HALF); c++) begin
                tick(lvl, 1'b0);
                vectors++;
                if (dut_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL sclr_pre cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
                end
            end
        end
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL sclr_prelock locked=%b exp 1", locked);
        end
        tick(lvl, 1'b1);
        vectors++;
        if (dut_vec() !== 10'd0) begin
            miscompares++;
            $display("FAIL sclr_mid got=%b exp=%b", dut_vec(), 10'd0);
        end
        for (int c = 0; c < 12; c++) begin
            tick(lvl, 1'b0);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL sclr_post cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int h = 0; h < 30; h++) begin
            lvl = ~lvl;
            for (int c = 0; c < ((h < 10) ? 1 : int'(HALF)); c++) begin
                tick(lvl, 1'b0);
                vectors++;
                if (dut_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
                end
            end
        end
    endtask

    task automatic test_random();
        int len;
        for (int h = 0; h < 400; h++) begin
            if ($urandom_range(0, 49) == 0) begin
                tick(lvl, 1'b1);
                vectors++;
                if (dut_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL random_sclr cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
                end
            end
            len = ($urandom_range(0, 9) < 6) ? int'($urandom_range(3, 5)) : int'($urandom_range(1, 14));
            lvl = ~lvl;
            for (int c = 0; c < len; c++) begin
                tick(lvl, 1'b0);
                vectors++;
                if (dut_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL random cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_freq_err();
        test_lost();
        test_tolerance();
        test_sclr_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
